// File: rtl/prim_byte_packer_pkg.sv
// Shared types and sizing helpers for the byte packer and its compaction stage.
// Sizing helpers are functions so they can seed localparams in any parameterisation.
package prim_byte_packer_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StWait  = 2'd2
    } state_e;

    localparam int unsigned MaxBytes = 64;

    function automatic int unsigned in_bytes(input int unsigned in_w);
        return in_w / 8;
    endfunction

    function automatic int unsigned out_bytes(input int unsigned out_w);
        return out_w / 8;
    endfunction

    // Worst case: OutB-1 leftover bytes plus one full input beat.
    function automatic int unsigned buf_bytes(input int unsigned in_w, input int unsigned out_w);
        return in_w / 8 + out_w / 8 - 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned in_w, input int unsigned out_w);
        return $clog2(buf_bytes(in_w, out_w) + 1);
    endfunction

    function automatic int unsigned popcount(input logic [MaxBytes-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MaxBytes; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prim_byte_compact.sv
// Combinational byte compactor: enabled bytes move to the bottom in ascending order.
// Zero latency, no state; bytes above the kept count are driven to zero.
module prim_byte_compact
    import prim_byte_packer_pkg::*;
#(
    parameter int InW  = 32,
    parameter int CntW = $clog2(InW / 8 + 1)
) (
    input  logic [InW-1:0]   data,
    input  logic [InW/8-1:0] mask,
    output logic [InW-1:0]   comp_data,
    output logic [CntW-1:0]  cnt
);

    localparam int InB = InW / 8;

    int idx;

    always_comb begin
        comp_data = '0;
        idx       = 0;
        for (int k = 0; k < InB; k++) begin
            if (mask[k]) begin
                comp_data[8*idx +: 8] = data[8*k +: 8];
                idx++;
            end
        end
    end

    assign cnt = CntW'(popcount(MaxBytes'(mask)));

endmodule

// File: rtl/prim_byte_packer.sv
// Byte packer: compacts masked input beats into full output words, with flush/drain.
// Accepted beat reaches valid_o two cycles later; ready_o drops when the buffer cannot absorb a beat.
module prim_byte_packer
    import prim_byte_packer_pkg::*;
#(
    parameter int InW  = 32,
    parameter int OutW = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [InW-1:0]    data_i,
    input  logic [InW/8-1:0]  mask_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [OutW-1:0]   data_o,
    output logic [OutW/8-1:0] mask_o,
    input  logic              ready_i,
    input  logic              flush_i,
    output logic              flush_done_o
);

    localparam int InB  = in_bytes(InW);
    localparam int OutB = out_bytes(OutW);
    localparam int BufB = buf_bytes(InW, OutW);
    localparam int PtrW = ptr_width(InW, OutW);
    localparam int BufW = BufB * 8;
    localparam int CntW = $clog2(InB + 1);
    localparam logic [PtrW-1:0] OutBP = PtrW'(OutB);

    state_e          state;
    logic [BufW-1:0] buf_q;
    logic [BufW-1:0] buf_d;
    logic [PtrW-1:0] pos_q;
    logic [PtrW-1:0] pos_eff;
    logic [PtrW-1:0] pos_d;
    logic [InW-1:0]  comp_data;
    logic [CntW-1:0] comp_cnt;
    logic            out_free;
    logic            full_move;
    logic            part_move;
    logic            accept;
    logic [OutB-1:0] part_mask;
    logic [OutW-1:0] part_data;

    prim_byte_compact #(
        .InW  (InW),
        .CntW (CntW)
    ) u_compact (
        .data      (data_i),
        .mask      (mask_i),
        .comp_data (comp_data),
        .cnt       (comp_cnt)
    );

    assign out_free  = !valid_o || ready_i;
    assign full_move = out_free && (pos_q >= OutBP);
    assign part_move = out_free && (state == StDrain) && (pos_q != '0) && (pos_q < OutBP);

    always_comb begin
        pos_eff = pos_q;
        if (full_move) begin
            pos_eff = pos_q - OutBP;
        end else if (part_move) begin
            pos_eff = '0;
        end
    end

    // Depends on ready_i through out_free, never on the input beat itself.
    assign ready_o      = (state == StRun) && (pos_eff < OutBP);
    assign accept       = valid_i && ready_o;
    assign flush_done_o = (state == StWait) && out_free;

    // Bytes at and above pos are always zero, so a new beat can be OR-ed in.
    always_comb begin
        buf_d = buf_q;
        if (full_move) begin
            buf_d = buf_q >> OutW;
        end else if (part_move) begin
            buf_d = '0;
        end
        if (accept) begin
            buf_d = buf_d | (BufW'(comp_data) << {pos_eff, 3'b000});
        end
    end

    assign pos_d = accept ? (pos_eff + PtrW'(comp_cnt)) : pos_eff;

    always_comb begin
        part_mask = '0;
        part_data = '0;
        for (int b = 0; b < OutB; b++) begin
            part_mask[b] = (PtrW'(b) < pos_q);
            if (part_mask[b]) begin
                part_data[8*b +: 8] = buf_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
            pos_q <= '0;
        end else begin
            buf_q <= buf_d;
            pos_q <= pos_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            mask_o  <= '0;
        end else if (full_move) begin
            valid_o <= 1'b1;
            data_o  <= buf_q[OutW-1:0];
            mask_o  <= '1;
        end else if (part_move) begin
            valid_o <= 1'b1;
            data_o  <= part_data;
            mask_o  <= part_mask;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // A beat accepted alongside flush_i is already counted in pos_d.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= StRun;
        end else begin
            case (state)
                StRun:   if (flush_i) state <= StDrain;
                StDrain: if (pos_d == '0) state <= StWait;
                StWait:  if (out_free) state <= StRun;
                default: state <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_prim_byte_packer.sv
// Bench for prim_byte_packer: byte-queue reference model plus directed literal cases.
module tb_prim_byte_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        valid, rdy, flush;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        d_ready, d_valid, d_done;
    logic [31:0] d_data;
    logic [3:0]  d_mask;

    logic        v2;
    logic [31:0] d2;
    logic [3:0]  m2 = 4'hF;
    logic        w_ready, w_valid, w_done;
    logic [63:0] w_data;
    logic [7:0]  w_mask;

    logic        v3;
    logic [63:0] d3;
    logic [7:0]  m3 = 8'hFF;
    logic        n_ready, n_valid, n_done;
    logic [31:0] n_data;
    logic [3:0]  n_mask;

    logic one = 1'b1;
    logic zero = 1'b0;

    prim_byte_packer #(.InW(32), .OutW(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .mask_i(mask),
        .ready_o(d_ready), .valid_o(d_valid), .data_o(d_data), .mask_o(d_mask),
        .ready_i(rdy), .flush_i(flush), .flush_done_o(d_done)
    );

    prim_byte_packer #(.InW(32), .OutW(64)) u_dut_w (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .data_i(d2), .mask_i(m2),
        .ready_o(w_ready), .valid_o(w_valid), .data_o(w_data), .mask_o(w_mask),
        .ready_i(one), .flush_i(zero), .flush_done_o(w_done)
    );

    prim_byte_packer #(.InW(64), .OutW(32)) u_dut_n (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .data_i(d3), .mask_i(m3),
        .ready_o(n_ready), .valid_o(n_valid), .data_o(n_data), .mask_o(n_mask),
        .ready_i(one), .flush_i(zero), .flush_done_o(n_done)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  q[$];
    logic [31:0] seen_d[$];
    logic [3:0]  seen_m[$];
    bit          flushing = 0;
    int          rem = 0;
    int          fl_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_d;
    logic [3:0]  prev_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input int i, input logic [31:0] ed, input logic [3:0] em);
        chk({name, "_present"}, 64'(seen_d.size() > i), 64'd1);
        if (seen_d.size() > i) begin
            chk(name, 64'(seen_d[i]), 64'(ed));
            chk({name, "_mask"}, 64'(seen_m[i]), 64'(em));
        end
    endtask

    function automatic logic [63:0] mkword(input logic [7:0] b, input int n);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = b + 8'(k);
        return w;
    endfunction

    // Reference model: a FIFO of kept bytes; every output word must pop its bytes in order.
    always @(negedge clk) begin
        bit          pf;
        logic [3:0]  em;
        logic [31:0] ew;
        int          n;
        if (!rst_n) begin
            q.delete();
            flushing   = 0;
            prev_stall = 0;
            fl_cnt     = 0;
            rem        = 0;
        end else begin
            pf = flushing;
            if (prev_stall) begin
                chk("stall_valid", 64'(d_valid), 64'd1);
                chk("stall_data", 64'(d_data), 64'(prev_d));
                chk("stall_mask", 64'(d_mask), 64'(prev_m));
            end
            if (pf) chk("ready_in_flush", 64'(d_ready), 64'd0);
            if (d_valid && rdy) begin
                if (!pf || rem >= 4) em = 4'hF;
                else em = 4'((1 << rem) - 1);
                chk("word_mask", 64'(d_mask), 64'(em));
                ew = '0;
                n  = 0;
                for (int k = 0; k < 4; k++) begin
                    if (em[k]) begin
                        if (q.size() > 0) begin
                            ew[8*k +: 8] = q.pop_front();
                        end else begin
                            checks++;
                            failures++;
                            $display("FAIL underflow: word popped with %0d bytes left, needed byte %0d", q.size(), k);
                        end
                        n++;
                    end
                end
                chk("word_data", 64'(d_data), 64'(ew));
                seen_d.push_back(d_data);
                seen_m.push_back(d_mask);
                if (pf) rem -= n;
            end
            if (valid && d_ready) begin
                for (int k = 0; k < 4; k++) if (mask[k]) q.push_back(data[8*k +: 8]);
            end
            if (d_done) begin
                chk("done_ctx", {61'd0, pf, rem == 0, q.size() == 0}, 64'd7);
                flushing = 0;
            end else if (pf) begin
                fl_cnt++;
                if (fl_cnt == 100) begin
                    checks++;
                    failures++;
                    $display("FAIL drain_timeout: no flush_done after %0d cycles, got 0 expected 1", fl_cnt);
                    flushing = 0;
                end
            end
            if (flush && !pf) begin
                flushing = 1;
                rem      = q.size();
                fl_cnt   = 0;
            end
            prev_stall = d_valid && !rdy;
            prev_d     = d_data;
            prev_m     = d_mask;
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] m);
        int t;
        valid = 1'b1;
        data  = d;
        mask  = m;
        t     = 0;
        @(negedge clk);
        while (!d_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_accept", 64'(d_ready), 64'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int  t;
        bit  got;
        t   = 0;
        got = 0;
        while (!got && t < 60) begin
            @(negedge clk);
            got = d_done;
            t++;
        end
        chk(name, 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pv;
        bit acc;
        logic [7:0] bw, ow;
        rst_n = 1'b0;
        valid = 0; data = '0; mask = '0; rdy = 1; flush = 0;
        v2 = 0; d2 = '0; v3 = 0; d3 = '0;
        #2;
        chk("rst_valid", 64'(d_valid), 64'd0);
        chk("rst_data", 64'(d_data), 64'd0);
        chk("rst_mask", 64'(d_mask), 64'd0);
        chk("rst_done", 64'(d_done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);

        // Two half-beats combine into one word, two cycles after the second accept.
        send(32'hAABBCCDD, 4'b0011);
        send(32'h11223344, 4'b0011);
        chk("t1_valid_n1", 64'(d_valid), 64'd0);
        cyc(1);
        chk("t1_valid_n2", 64'(d_valid), 64'd1);
        chk("t1_data", 64'(d_data), 64'h3344CCDD);
        chk("t1_mask", 64'(d_mask), 64'hF);
        cyc(2);

        send(32'h11223344, 4'b1010);
        send(32'h11223344, 4'b1010);
        cyc(1);
        chk("t2_data", 64'(d_data), 64'h11331133);
        cyc(2);

        // Backpressure: output held, input refused, then everything drains in order.
        seen_d.delete(); seen_m.delete();
        rdy = 0;
        send(32'h03020100, 4'hF);
        send(32'h07060504, 4'hF);
        valid = 1; data = 32'h0B0A0908; mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_ready_low", 64'(d_ready), 64'd0);
            chk("t3_hold_valid", 64'(d_valid), 64'd1);
            chk("t3_hold_data", 64'(d_data), 64'h03020100);
            @(posedge clk);
            #1;
        end
        rdy = 1;
        send(32'h0B0A0908, 4'hF);
        cyc(5);
        chk_word("t3_w0", 0, 32'h03020100, 4'hF);
        chk_word("t3_w1", 1, 32'h07060504, 4'hF);
        chk_word("t3_w2", 2, 32'h0B0A0908, 4'hF);

        // Flush of a 3-byte remainder.
        seen_d.delete(); seen_m.delete();
        send(32'hDDCCBBAA, 4'b0111);
        flush = 1;
        cyc(1);
        flush = 0;
        wait_done("t4_done");
        chk_word("t4_word", 0, 32'h00CCBBAA, 4'b0111);

        // Empty flush: Run -> Drain -> Wait, pulse two cycles after the request.
        flush = 1;
        @(negedge clk);
        chk("t5_done_c0", 64'(d_done), 64'd0);
        @(posedge clk);
        #1;
        flush = 0;
        @(negedge clk);
        chk("t5_done_c1", 64'(d_done), 64'd0);
        @(negedge clk);
        chk("t5_done_c2", 64'(d_done), 64'd1);
        cyc(2);

        // Reset mid-stream with five bytes buffered and a word on the output.
        rdy = 0;
        send(32'hA3A2A1A0, 4'hF);
        send(32'h00B2B1B0, 4'b0111);
        send(32'h0000C1C0, 4'b0011);
        rst_n = 0;
        #1;
        chk("t6_valid", 64'(d_valid), 64'd0);
        chk("t6_data", 64'(d_data), 64'd0);
        chk("t6_mask", 64'(d_mask), 64'd0);
        chk("t6_done", 64'(d_done), 64'd0);
        cyc(2);
        rst_n = 1;
        rdy = 1;
        seen_d.delete(); seen_m.delete();
        send(32'h44332211, 4'hF);
        cyc(4);
        chk_word("t6_word", 0, 32'h44332211, 4'hF);
        chk("t6_count", 64'(seen_d.size()), 64'd1);

        // Randomized traffic, backpressure and flushes against the model.
        for (int i = 0; i < 1500; i++) begin
            valid = 1'($urandom_range(0, 1));
            data  = $urandom;
            mask  = 4'($urandom_range(0, 15));
            rdy   = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 29) == 0);
            cyc(1);
        end
        valid = 0; flush = 0; rdy = 1;
        cyc(20);
        flush = 1;
        cyc(1);
        flush = 0;
        wait_done("final_done");
        chk("final_empty", 64'(q.size()), 64'd0);

        // 32 -> 64: input never stalls, one output every two beats.
        bw = 8'h00; ow = 8'h00; pv = 0;
        v2 = 1;
        for (int i = 0; i < 40; i++) begin
            d2 = mkword(bw, 4)[31:0];
            @(negedge clk);
            chk("w_ready", 64'(w_ready), 64'd1);
            chk("w_done", 64'(w_done), 64'd0);
            if (w_valid) begin
                chk("w_data", w_data, mkword(ow, 8));
                chk("w_mask", 64'(w_mask), 64'hFF);
                ow = ow + 8'd8;
            end
            if (i >= 4) chk("w_toggle", 64'(w_valid), 64'(!pv));
            pv  = w_valid;
            acc = w_ready;
            @(posedge clk);
            #1;
            if (acc) bw = bw + 8'd4;
        end
        v2 = 0;

        // 64 -> 32: output every cycle, input every other cycle.
        bw = 8'h40; ow = 8'h40; pv = 0;
        v3 = 1;
        for (int i = 0; i < 40; i++) begin
            d3 = mkword(bw, 8);
            @(negedge clk);
            chk("n_done", 64'(n_done), 64'd0);
            if (i >= 2) chk("n_valid", 64'(n_valid), 64'd1);
            if (i >= 1) chk("n_ready_alt", 64'(n_ready), 64'(!pv));
            if (n_valid) begin
                chk("n_data", 64'(n_data), 64'(mkword(ow, 4)[31:0]));
                chk("n_mask", 64'(n_mask), 64'hF);
                ow = ow + 8'd4;
            end
            pv  = n_ready;
            acc = n_ready;
            @(posedge clk);
            #1;
            if (acc) bw = bw + 8'd8;
        end
        v3 = 0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
